// File: rtl/img_pkg.sv
// Pixel types and image geometry shared by the
// window generator and its neighbours.
package img_pkg;

  localparam int PIX_W = 24;
  typedef logic [PIX_W-1:0] pixel_t;

  localparam int G_LO = 0;
  localparam int G_HI = 7;
  localparam int B_LO = 8;
  localparam int B_HI = 15;
  localparam int R_LO = 16;
  localparam int R_HI = 23;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, 3x3 window out.
// The master drives pixels; the slave produces windows.
interface window_gen_3x3_if;
  import img_pkg::*;

  pixel_t pix_in;
  logic   pix_valid;
  logic   sof;

  pixel_t window_0;
  pixel_t window_1;
  pixel_t window_2;
  pixel_t window_3;
  pixel_t window_4;
  pixel_t window_5;
  pixel_t window_6;
  pixel_t window_7;
  pixel_t window_8;
  logic   win_valid;
  logic   win_sof;

  modport master (
    output pix_in, pix_valid, sof,
    input  window_0, window_1, window_2,
    input  window_3, window_4, window_5,
    input  window_6, window_7, window_8,
    input  win_valid, win_sof
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output window_0, window_1, window_2,
    output window_3, window_4, window_5,
    output window_6, window_7, window_8,
    output win_valid, win_sof
  );

endinterface

// File: rtl/line_buffer.sv
// One image line of storage: async read, sync write,
// so a same-cycle access returns the old entry.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster stream to 3x3 neighbourhood generator.
// Emits only windows that lie fully inside the image.
module window_gen_3x3
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input logic             clk,
  input logic             n_rst,
  window_gen_3x3_if.slave bus
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] TWO_C  = CW'(2);
  localparam logic [RW-1:0] TWO_R  = RW'(2);

  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;

  pixel_t win_q [9];
  pixel_t win_d [9];
  logic   win_valid_q, win_valid_d;
  logic   win_sof_q, win_sof_d;

  pixel_t lb0_rd, lb1_rd;
  logic   accept;

  assign accept = bus.pix_valid;

  // sof forces the accepted pixel to (0,0) even mid-frame
  always_comb begin
    col_c = bus.sof ? '0 : col_q;
    row_c = bus.sof ? '0 : row_q;
  end

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_c),
    .wdata_i (bus.pix_in),
    .rdata_o (lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_c),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_c == LAST_C) begin
        col_d = '0;
        row_d = (row_c == LAST_R) ? '0 : row_c + 1'b1;
      end else begin
        col_d = col_c + 1'b1;
        row_d = row_c;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        win_d[3*k]   = win_q[3*k+1];
        win_d[3*k+1] = win_q[3*k+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = bus.pix_in;
    end
  end

  // stale columns at line start fall under col<2 and stay unflagged
  always_comb begin
    win_valid_d = accept && (row_c >= TWO_R) && (col_c >= TWO_C);
    win_sof_d   = win_valid_d && (row_c == TWO_R) && (col_c == TWO_C);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_sof_q   <= win_sof_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign bus.window_0  = win_q[0];
  assign bus.window_1  = win_q[1];
  assign bus.window_2  = win_q[2];
  assign bus.window_3  = win_q[3];
  assign bus.window_4  = win_q[4];
  assign bus.window_5  = win_q[5];
  assign bus.window_6  = win_q[6];
  assign bus.window_7  = win_q[7];
  assign bus.window_8  = win_q[8];
  assign bus.win_valid = win_valid_q;
  assign bus.win_sof   = win_sof_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image against a
// coordinate-indexed frame model.
module tb_window_gen_3x3;
  import img_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  window_gen_3x3_if wif();

  window_gen_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (wif)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  int     pulses = 0;
  pixel_t fr [H][W];
  pixel_t expw [9];
  logic   known;
  logic   ev;
  logic   es;
  int     mr;
  int     mc;

  function automatic pixel_t px(int r, int c);
    logic [7:0] b;
    b = 8'(r * 16 + c);
    return {b, b, b};
  endfunction

  function automatic pixel_t obs(int i);
    case (i)
      0: return wif.window_0;
      1: return wif.window_1;
      2: return wif.window_2;
      3: return wif.window_3;
      4: return wif.window_4;
      5: return wif.window_5;
      6: return wif.window_6;
      7: return wif.window_7;
      default: return wif.window_8;
    endcase
  endfunction

  task automatic chk(string tag, pixel_t o, pixel_t e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_out();
    chk("win_valid", pixel_t'(wif.win_valid), pixel_t'(ev));
    chk("win_sof", pixel_t'(wif.win_sof), pixel_t'(es));
    if (wif.win_valid === 1'b1) pulses++;
    if (known) begin
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("window_%0d", i), obs(i), expw[i]);
      end
    end
  endtask

  // Expected outputs follow the image coordinates of each accept
  task automatic model(logic v, logic s, pixel_t p);
    int r;
    int c;
    if (!v) begin
      ev = 1'b0;
      es = 1'b0;
    end else begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      fr[r][c] = p;
      ev = (r >= 2) && (c >= 2);
      es = ev && (r == 2) && (c == 2);
      known = ev;
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            expw[i*3+j] = fr[r-2+i][c-2+j];
      end
      mc = c + 1;
      mr = r;
      if (mc == W) begin
        mc = 0;
        mr = (r == H - 1) ? 0 : r + 1;
      end
    end
  endtask

  task automatic send(logic v, logic s, pixel_t p);
    @(negedge clk);
    wif.pix_valid = v;
    wif.sof       = s;
    wif.pix_in    = p;
    @(posedge clk);
    model(v, s, p);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst         = 1'b0;
    wif.pix_valid = 1'b1;
    wif.sof       = 1'b0;
    wif.pix_in    = pixel_t'($urandom);
    repeat (2) @(posedge clk);
    mr = 0;
    mc = 0;
    ev = 1'b0;
    es = 1'b0;
    known = 1'b1;
    for (int i = 0; i < 9; i++) expw[i] = '0;
    #1;
    check_out();
    @(negedge clk);
    n_rst         = 1'b1;
    wif.pix_valid = 1'b0;
    wif.sof       = 1'b0;
  endtask

  task automatic send_frame(int gap, bit rnd, bit use_sof, int npix);
    for (int k = 0; k < npix; k++) begin
      while ($urandom_range(0, 99) < gap)
        send(1'b0, 1'b0, pixel_t'($urandom));
      send(1'b1, use_sof && (k == 0),
           rnd ? pixel_t'($urandom) : px(k / W, k % W));
    end
  endtask

  initial begin
    wif.pix_valid = 1'b0;
    wif.sof       = 1'b0;
    wif.pix_in    = '0;
    known = 1'b0;
    ev    = 1'b0;
    es    = 1'b0;
    mr    = 0;
    mc    = 0;

    // reset with pixels offered
    do_reset();

    // contiguous frame
    pulses = 0;
    send_frame(0, 1'b0, 1'b1, W * H);
    chk("pulses_contig", pixel_t'(pulses), pixel_t'(4));
    chk("last_w0", wif.window_0, 24'h111111);
    chk("last_w4", wif.window_4, 24'h222222);
    chk("last_w8", wif.window_8, 24'h333333);

    // gaps of about 30%
    pulses = 0;
    send_frame(30, 1'b0, 1'b1, W * H);
    repeat (3) send(1'b0, 1'b0, pixel_t'($urandom));
    chk("pulses_gaps", pixel_t'(pulses), pixel_t'(4));

    // sof on the (2,1) slot restarts the frame
    pulses = 0;
    send_frame(0, 1'b0, 1'b1, 2 * W + 1);
    send_frame(0, 1'b0, 1'b1, W * H);
    chk("pulses_midsof", pixel_t'(pulses), pixel_t'(4));

    // reset after (2,3), then a clean frame
    pulses = 0;
    send_frame(0, 1'b0, 1'b1, 3 * W);
    chk("pulses_prefix", pixel_t'(pulses), pixel_t'(2));
    do_reset();
    pulses = 0;
    send_frame(0, 1'b0, 1'b1, W * H);
    chk("pulses_after_rst", pixel_t'(pulses), pixel_t'(4));

    // random data, then a wrapped frame without sof
    pulses = 0;
    send_frame(30, 1'b1, 1'b1, W * H);
    send_frame(30, 1'b1, 1'b0, W * H);
    chk("pulses_wrap", pixel_t'(pulses), pixel_t'(8));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
